mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares one single-ported, variable-latency unified memory between the pipeline's instruction-fetch port (I) and data-access port (D).
- Sits between the CPU pipeline and the memory.
- Serialises requests, holds the memory handshake, and returns per-port completion pulses. The pipeline uses these pulses to drive PCWrite/IFID_Write-style stalls.
- Provides data-priority arbitration with anti-starvation for fetch, plus a timeout watchdog.

Parameters:
ADDR_W, 32, address width (byte address)
DATA_W, 32, data width
MAX_D_BURST, 4, maximum consecutive D grants while I is pending before I is forced through
TIMEOUT, 255, cycles in BUSY without mem_ack before the transaction is aborted (1..65535)

Ports:
clock  in  1  system clock, all state on rising edge
reset  in  1  synchronous, active-low reset
i_req  in  1  fetch request; held high with stable i_addr until i_ready
i_addr  in  ADDR_W  fetch address
i_ready  out  1  fetch completion pulse (combinational)
i_rdata  out  DATA_W  fetch data, valid when i_ready
i_err  out  1  fetch aborted by timeout, valid when i_ready
d_req  in  1  data request; held high with stable d_we/d_addr/d_wdata until d_ready
d_we  in  1  1 = write, 0 = read
d_addr  in  ADDR_W  data address
d_wdata  in  DATA_W  write data
d_ready  out  1  data completion pulse (combinational)
d_rdata  out  DATA_W  read data, valid when d_ready and !d_we
d_err  out  1  data aborted by timeout, valid when d_ready
mem_req  out  1  registered; high for the whole transaction
mem_we  out  1  registered write enable
mem_addr  out  ADDR_W  registered address
mem_wdata  out  DATA_W  registered write data
mem_ack  in  1  memory completion, one cycle; honoured only while mem_req=1
mem_rdata  in  DATA_W  read data, valid with mem_ack

Behaviour:
- States: IDLE, BUSY_I, BUSY_D. The timeout is handled inside the BUSY states.
- Reset (reset=0 at a clock edge):
  - state=IDLE; mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0; burst counter=0; wait counter=0.
  - i_ready, d_ready, i_err and d_err are 0 in IDLE.
  - Reset mid-transaction abandons it: no ready pulse is issued, and mem_req drops at that edge.
- IDLE arbitration, evaluated each cycle:
  - If only one port requests, grant it.
  - If both request, grant D unless burst_cnt==MAX_D_BURST, in which case grant I.
  - If neither requests, remain in IDLE.
  - On a grant, at the next edge: latch mem_addr (plus mem_we and mem_wdata for D; mem_we=0 for I), set mem_req=1, clear wait_cnt, and enter BUSY_x.
- Burst counter (saturating):
  - Increments on each D grant made while i_req=1.
  - Clears on an I grant, or in any IDLE cycle with i_req=0.
- BUSY_x with mem_ack=1:
  - x_ready=1 in the same cycle; x_rdata=mem_rdata passes through; x_err=0.
  - Next edge: state=IDLE, mem_req=0, mem_we=0.
  - A requester advances on that edge, so a held request is never re-issued.
- BUSY_x with mem_ack=0:
  - wait_cnt increments (16-bit).
  - When wait_cnt==TIMEOUT-1 and no ack arrives: x_ready=1, x_err=1, x_rdata=0 that cycle; next edge goes to IDLE with mem_req=0.
  - A mem_ack arriving in that same cycle takes precedence: normal completion with err=0.
- Minimum transaction:
  - Request seen in IDLE at cycle N; mem_req high from N+1.
  - Earliest ready is at N+1 if mem_ack returns immediately.
  - Throughput is one transaction per 2 cycles at best (IDLE cycle between transactions).
- No preemption: the unselected port waits with ready=0. Ports never receive ready while in another port's BUSY state.
- mem_ack while in IDLE is ignored.
- Both ready outputs are never high in the same cycle.
- Inputs of the non-granted port may change freely. The granted port's inputs are sampled only at grant.

Test Plan:
1. Single fetch: i_req=1, i_addr=0x40; memory acks 3 cycles after mem_req with 0x8C010004 -> mem_addr=0x40, mem_we=0; i_ready pulses once with i_rdata=0x8C010004 and i_err=0; mem_req low the next cycle.
2. Simultaneous requests: i_req=d_req=1 (d_we=1, d_addr=0x100, d_wdata=0xDEADBEEF), ack latency 1 -> D served first (mem_we=1, mem_wdata=0xDEADBEEF), I served on the following grant; exactly one ready pulse each.
3. Starvation: i_req held high, d_req held high across 6 D transactions with MAX_D_BURST=4 -> grant order D,D,D,D,I,D; burst counter back to 0 after the I grant.
4. Timeout: TIMEOUT=8, d_req read, never ack -> d_ready=1 and d_err=1 with d_rdata=0 on the 8th BUSY cycle; mem_req low next cycle; a subsequent i_req completes normally.
5. Ack on timeout boundary: mem_ack arrives in the same cycle wait_cnt==TIMEOUT-1 with data 0x1234 -> ready=1, err=0, rdata=0x1234.
6. Reset mid-operation: reset=0 during BUSY_D -> next edge mem_req=0, state IDLE, no d_ready pulse; a stray mem_ack after reset is ignored; operation resumes normally after reset=1.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Arbitrates a single-ported, variable-latency memory between the fetch (I) and data (D) ports.
// D has priority, a saturating burst counter forces a waiting fetch through, and a watchdog aborts stuck accesses.
module mem_port_arbiter #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int MAX_D_BURST = 4,
  parameter int TIMEOUT     = 255
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_ready,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_err,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ready,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_err,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } state_t;

  localparam int                 BURST_W   = (MAX_D_BURST > 0) ? $clog2(MAX_D_BURST + 1) : 1;
  localparam logic [BURST_W-1:0] BURST_MAX = BURST_W'(MAX_D_BURST);
  localparam logic [15:0]        WAIT_LAST = 16'(TIMEOUT - 1);

  state_t              state_reg, state_next;
  logic [BURST_W-1:0]  burst_cnt_reg, burst_cnt_next;
  logic [15:0]         wait_cnt_reg, wait_cnt_next;
  logic                mem_req_reg, mem_req_next;
  logic                mem_we_reg, mem_we_next;
  logic [ADDR_W-1:0]   mem_addr_reg, mem_addr_next;
  logic [DATA_W-1:0]   mem_wdata_reg, mem_wdata_next;

  logic                busy_done;
  logic                busy_err;
  logic [DATA_W-1:0]   busy_rdata;
  logic                grant_i;

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_reg     <= IDLE;
      burst_cnt_reg <= '0;
      wait_cnt_reg  <= '0;
      mem_req_reg   <= 1'b0;
      mem_we_reg    <= 1'b0;
      mem_addr_reg  <= '0;
      mem_wdata_reg <= '0;
    end else begin
      state_reg     <= state_next;
      burst_cnt_reg <= burst_cnt_next;
      wait_cnt_reg  <= wait_cnt_next;
      mem_req_reg   <= mem_req_next;
      mem_we_reg    <= mem_we_next;
      mem_addr_reg  <= mem_addr_next;
      mem_wdata_reg <= mem_wdata_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    burst_cnt_next = burst_cnt_reg;
    wait_cnt_next  = wait_cnt_reg;
    mem_req_next   = mem_req_reg;
    mem_we_next    = mem_we_reg;
    mem_addr_next  = mem_addr_reg;
    mem_wdata_next = mem_wdata_reg;
    busy_done      = 1'b0;
    busy_err       = 1'b0;
    busy_rdata     = '0;
    grant_i        = i_req && (!d_req || (burst_cnt_reg == BURST_MAX));

    case (state_reg)
      IDLE: begin
        if (!i_req) begin
          burst_cnt_next = '0;
        end
        if (grant_i) begin
          state_next     = BUSY_I;
          mem_req_next   = 1'b1;
          mem_we_next    = 1'b0;
          mem_addr_next  = i_addr;
          wait_cnt_next  = '0;
          burst_cnt_next = '0;
        end else if (d_req) begin
          state_next     = BUSY_D;
          mem_req_next   = 1'b1;
          mem_we_next    = d_we;
          mem_addr_next  = d_addr;
          mem_wdata_next = d_wdata;
          wait_cnt_next  = '0;
          // Only D grants that make a pending fetch wait count toward the burst.
          if (i_req && (burst_cnt_reg != BURST_MAX)) begin
            burst_cnt_next = burst_cnt_reg + BURST_W'(1);
          end
        end
      end
      BUSY_I, BUSY_D: begin
        if (mem_ack) begin
          busy_done  = 1'b1;
          busy_rdata = mem_rdata;
        end else if (wait_cnt_reg == WAIT_LAST) begin
          busy_done = 1'b1;
          busy_err  = 1'b1;
        end else begin
          wait_cnt_next = wait_cnt_reg + 16'd1;
        end
        if (busy_done) begin
          state_next   = IDLE;
          mem_req_next = 1'b0;
          mem_we_next  = 1'b0;
        end
      end
      default: begin
        state_next   = IDLE;
        mem_req_next = 1'b0;
        mem_we_next  = 1'b0;
      end
    endcase
  end

  // Completion is suppressed while reset is asserted so an abandoned access never reports.
  always_comb begin
    i_ready = 1'b0;
    i_err   = 1'b0;
    i_rdata = '0;
    d_ready = 1'b0;
    d_err   = 1'b0;
    d_rdata = '0;
    if (reset && busy_done) begin
      if (state_reg == BUSY_I) begin
        i_ready = 1'b1;
        i_err   = busy_err;
        i_rdata = busy_rdata;
      end else if (state_reg == BUSY_D) begin
        d_ready = 1'b1;
        d_err   = busy_err;
        d_rdata = busy_rdata;
      end
    end
  end

  assign mem_req   = mem_req_reg;
  assign mem_we    = mem_we_reg;
  assign mem_addr  = mem_addr_reg;
  assign mem_wdata = mem_wdata_reg;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: fetch, contention, starvation, timeout, boundary ack and reset.
module tb_mem_port_arbiter;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        i_req = 1'b0;
  logic [31:0] i_addr = '0;
  logic        i_ready;
  logic [31:0] i_rdata;
  logic        i_err;
  logic        d_req = 1'b0;
  logic        d_we = 1'b0;
  logic [31:0] d_addr = '0;
  logic [31:0] d_wdata = '0;
  logic        d_ready;
  logic [31:0] d_rdata;
  logic        d_err;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = '0;

  int checks = 0;
  int errors = 0;

  logic [31:0] s_addr, s_wdata, s_ird, s_drd;
  logic        s_we, s_ir, s_dr, s_ie, s_de;

  mem_port_arbiter #(
    .ADDR_W(32),
    .DATA_W(32),
    .MAX_D_BURST(4),
    .TIMEOUT(8)
  ) dut (
    .clock(clock),
    .reset(reset),
    .i_req(i_req),
    .i_addr(i_addr),
    .i_ready(i_ready),
    .i_rdata(i_rdata),
    .i_err(i_err),
    .d_req(d_req),
    .d_we(d_we),
    .d_addr(d_addr),
    .d_wdata(d_wdata),
    .d_ready(d_ready),
    .d_rdata(d_rdata),
    .d_err(d_err),
    .mem_req(mem_req),
    .mem_we(mem_we),
    .mem_addr(mem_addr),
    .mem_wdata(mem_wdata),
    .mem_ack(mem_ack),
    .mem_rdata(mem_rdata)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  task automatic wait_req();
    int n = 0;
    while (mem_req !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    check("grant_seen", 32'(mem_req), 32'd1);
  endtask

  // Waits for a grant, holds mem_ack low for lat BUSY cycles, then acks with rdata.
  task automatic serve(input int lat, input logic [31:0] rdata,
                       output logic [31:0] addr, output logic we, output logic [31:0] wdata,
                       output logic ir, output logic dr, output logic [31:0] ird,
                       output logic [31:0] drd, output logic ie, output logic de);
    wait_req();
    addr  = mem_addr;
    we    = mem_we;
    wdata = mem_wdata;
    for (int k = 0; k < lat; k++) begin
      #1;
      check("no_early_ready", 32'({i_ready, d_ready}), 32'd0);
      tick();
    end
    mem_ack   = 1'b1;
    mem_rdata = rdata;
    #1;
    ir  = i_ready;
    dr  = d_ready;
    ird = i_rdata;
    drd = d_rdata;
    ie  = i_err;
    de  = d_err;
    check("ready_exclusive", 32'(i_ready & d_ready), 32'd0);
    tick();
    mem_ack   = 1'b0;
    mem_rdata = '0;
    check("req_drop", 32'(mem_req), 32'd0);
  endtask

  initial begin
    // Reset state
    tick();
    tick();
    check("rst_mem_req", 32'(mem_req), 32'd0);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'd0);
    check("rst_ready", 32'({i_ready, d_ready, i_err, d_err}), 32'd0);
    check("rst_burst", 32'(dut.burst_cnt_reg), 32'd0);
    reset = 1'b1;

    // 1: single fetch, ack after 3 wait cycles
    i_req  = 1'b1;
    i_addr = 32'h40;
    serve(3, 32'h8C010004, s_addr, s_we, s_wdata, s_ir, s_dr, s_ird, s_drd, s_ie, s_de);
    i_req = 1'b0;
    check("t1_addr", s_addr, 32'h40);
    check("t1_we", 32'(s_we), 32'd0);
    check("t1_i_ready", 32'(s_ir), 32'd1);
    check("t1_d_ready", 32'(s_dr), 32'd0);
    check("t1_i_rdata", s_ird, 32'h8C010004);
    check("t1_i_err", 32'(s_ie), 32'd0);
    #1;
    check("t1_ready_gone", 32'(i_ready), 32'd0);
    tick();
    check("t1_no_reissue", 32'(mem_req), 32'd0);

    // 2: simultaneous requests, D wins
    i_req   = 1'b1;
    i_addr  = 32'h44;
    d_req   = 1'b1;
    d_we    = 1'b1;
    d_addr  = 32'h100;
    d_wdata = 32'hDEADBEEF;
    serve(1, 32'h0, s_addr, s_we, s_wdata, s_ir, s_dr, s_ird, s_drd, s_ie, s_de);
    d_req = 1'b0;
    check("t2_d_addr", s_addr, 32'h100);
    check("t2_d_we", 32'(s_we), 32'd1);
    check("t2_d_wdata", s_wdata, 32'hDEADBEEF);
    check("t2_d_ready", 32'({s_ir, s_dr, s_de}), 32'b010);
    serve(1, 32'h11111111, s_addr, s_we, s_wdata, s_ir, s_dr, s_ird, s_drd, s_ie, s_de);
    i_req = 1'b0;
    check("t2_i_addr", s_addr, 32'h44);
    check("t2_i_we", 32'(s_we), 32'd0);
    check("t2_i_ready", 32'({s_ir, s_dr, s_ie}), 32'b100);
    check("t2_i_rdata", s_ird, 32'h11111111);
    tick();

    // 3: starvation guard, expected order D,D,D,D,I,D
    i_req  = 1'b1;
    i_addr = 32'h200;
    d_req  = 1'b1;
    d_we   = 1'b0;
    d_addr = 32'h300;
    for (int k = 0; k < 6; k++) begin
      serve(0, 32'h1000 + 32'(k), s_addr, s_we, s_wdata, s_ir, s_dr, s_ird, s_drd, s_ie, s_de);
      if (k == 4) begin
        check("t3_grant_addr", s_addr, 32'h200);
        check("t3_i_ready", 32'({s_ir, s_dr}), 32'b10);
        check("t3_i_rdata", s_ird, 32'h1004);
        check("t3_burst_after_i", 32'(dut.burst_cnt_reg), 32'd0);
      end else begin
        check("t3_grant_addr", s_addr, 32'h300);
        check("t3_d_ready", 32'({s_ir, s_dr}), 32'b01);
        check("t3_d_rdata", s_drd, 32'h1000 + 32'(k));
      end
      if (k == 3) check("t3_burst_sat", 32'(dut.burst_cnt_reg), 32'd4);
    end
    check("t3_burst_final", 32'(dut.burst_cnt_reg), 32'd1);
    i_req = 1'b0;
    d_req = 1'b0;
    tick();

    // 4: timeout on the 8th BUSY cycle, read data forced to zero
    d_req     = 1'b1;
    d_we      = 1'b0;
    d_addr    = 32'h400;
    mem_rdata = 32'hFFFF0000;
    wait_req();
    for (int k = 0; k < 7; k++) begin
      #1;
      check("t4_wait_no_ready", 32'(d_ready), 32'd0);
      tick();
    end
    #1;
    check("t4_d_ready", 32'(d_ready), 32'd1);
    check("t4_d_err", 32'(d_err), 32'd1);
    check("t4_d_rdata", d_rdata, 32'd0);
    check("t4_i_ready", 32'(i_ready), 32'd0);
    tick();
    d_req     = 1'b0;
    mem_rdata = '0;
    check("t4_req_drop", 32'(mem_req), 32'd0);
    i_req  = 1'b1;
    i_addr = 32'h80;
    serve(0, 32'hCAFE0001, s_addr, s_we, s_wdata, s_ir, s_dr, s_ird, s_drd, s_ie, s_de);
    i_req = 1'b0;
    check("t4_fetch_addr", s_addr, 32'h80);
    check("t4_fetch_ready", 32'({s_ir, s_ie}), 32'b10);
    check("t4_fetch_rdata", s_ird, 32'hCAFE0001);
    tick();

    // 5: ack lands on the timeout boundary cycle
    d_req  = 1'b1;
    d_we   = 1'b0;
    d_addr = 32'h500;
    serve(7, 32'h1234, s_addr, s_we, s_wdata, s_ir, s_dr, s_ird, s_drd, s_ie, s_de);
    d_req = 1'b0;
    check("t5_addr", s_addr, 32'h500);
    check("t5_d_ready", 32'(s_dr), 32'd1);
    check("t5_d_err", 32'(s_de), 32'd0);
    check("t5_d_rdata", s_drd, 32'h1234);
    tick();

    // 6: reset during BUSY_D, stray ack afterwards, then normal operation
    d_req   = 1'b1;
    d_we    = 1'b1;
    d_addr  = 32'h600;
    d_wdata = 32'h55;
    wait_req();
    check("t6_busy_we", 32'(mem_we), 32'd1);
    check("t6_busy_addr", mem_addr, 32'h600);
    reset   = 1'b0;
    mem_ack = 1'b1;
    #1;
    check("t6_no_ready_in_rst", 32'({i_ready, d_ready}), 32'd0);
    tick();
    check("t6_rst_req", 32'(mem_req), 32'd0);
    check("t6_rst_we", 32'(mem_we), 32'd0);
    check("t6_rst_addr", mem_addr, 32'd0);
    check("t6_rst_wdata", mem_wdata, 32'd0);
    d_req = 1'b0;
    reset = 1'b1;
    #1;
    check("t6_stray_ack", 32'({i_ready, d_ready}), 32'd0);
    tick();
    mem_ack = 1'b0;
    check("t6_idle_after_stray", 32'(mem_req), 32'd0);
    i_req  = 1'b1;
    i_addr = 32'h90;
    serve(2, 32'hABCD, s_addr, s_we, s_wdata, s_ir, s_dr, s_ird, s_drd, s_ie, s_de);
    i_req = 1'b0;
    check("t6_resume_addr", s_addr, 32'h90);
    check("t6_resume_ready", 32'({s_ir, s_dr, s_ie}), 32'b100);
    check("t6_resume_rdata", s_ird, 32'hABCD);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
